// File: rtl/scan_chain_controller_pkg.sv
// Shared types and constants for the project scan-chain sequencer.
package scan_pkg;
  typedef enum logic [2:0] {IDLE, SHIFT, LATCH, CAPTURE, DONE} state_e;

  localparam int BITS_PER_DESIGN = 8;
  localparam int IDX_W           = 9;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/scan_chain_controller_clk_gen.sv
// Scan clock divider: CLK_DIV cycles low then CLK_DIV cycles high while run_i is set.
module scan_clk_gen
  import scan_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic scan_clk_o,
  output logic fall_strobe_o,
  output logic rise_strobe_o
);
  localparam int            DW       = clog2_min1(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          clk_q, clk_d;
  logic          half_end;

  // Strobes mark the cycle whose closing edge flips the scan clock.
  assign half_end      = run_i && (div_q == DIV_LAST);
  assign rise_strobe_o = half_end && !clk_q;
  assign fall_strobe_o = half_end && clk_q;
  assign scan_clk_o    = clk_q;

  always_comb begin
    div_d = '0;
    clk_d = 1'b0;
    if (run_i) begin
      div_d = half_end ? '0 : div_q + DW'(1);
      clk_d = half_end ? ~clk_q : clk_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= '0;
      clk_q <= 1'b0;
    end else begin
      div_q <= div_d;
      clk_q <= clk_d;
    end
  end
endmodule

// File: rtl/scan_chain_controller.sv
// Frame sequencer for the daisy-chained project scan chain: shift, latch, capture,
// returning the selected project's outputs from the previous frame.
module scan_chain_controller
  import scan_pkg::*;
#(
  parameter int NUM_DESIGNS = 250,
  parameter int CLK_DIV     = 2
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       enable,
  input  logic [IDX_W-1:0]           active_select,
  input  logic [BITS_PER_DESIGN-1:0] inputs,
  output logic [BITS_PER_DESIGN-1:0] outputs,
  output logic                       ready,
  output logic                       busy,
  output logic                       scan_clk_out,
  output logic                       scan_data_out,
  output logic                       scan_select,
  output logic                       scan_latch_en,
  input  logic                       scan_data_in
);
  localparam int               NBITS     = NUM_DESIGNS * BITS_PER_DESIGN;
  localparam int               CW        = clog2_min1(NBITS);
  localparam logic [CW-1:0]    LAST_BIT  = CW'(NBITS - 1);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_DESIGNS - 1);

  state_e                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]           sel_q, sel_d, slot;
  logic [BITS_PER_DESIGN-1:0] in_q, in_d, buf_q, buf_d, out_q, out_d;
  logic                       rdy_q, rdy_d;
  logic                       snap, hit, run, sclk, fall, rise;
  logic [2:0]                 bsel;

  // The divider keeps running through LATCH so its period times that state too.
  assign run = (state_q == SHIFT) || (state_q == LATCH) || (state_q == CAPTURE);

  scan_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk (
    .clk_i        (wb_clk_i),
    .rst_i        (wb_rst_i),
    .run_i        (run),
    .scan_clk_o   (sclk),
    .fall_strobe_o(fall),
    .rise_strobe_o(rise)
  );

  // Bit c travels to slot N-1-c/8, bit 7-c%8; the same mapping applies on return.
  assign slot = LAST_SLOT - IDX_W'(cnt_q >> 3);
  assign bsel = ~cnt_q[2:0];
  assign hit  = (slot == sel_q);

  assign scan_data_out = hit & in_q[bsel];
  assign scan_select   = (state_q == CAPTURE);
  assign scan_latch_en = (state_q == LATCH);
  assign scan_clk_out  = sclk & ~scan_latch_en;
  assign busy          = (state_q != IDLE);
  assign outputs       = out_q;
  assign ready         = rdy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    in_d    = in_q;
    buf_d   = buf_q;
    out_d   = out_q;
    rdy_d   = 1'b0;
    snap    = 1'b0;
    case (state_q)
      IDLE: snap = enable;
      SHIFT: begin
        if (rise && hit) buf_d[bsel] = scan_data_in;
        if (fall) begin
          if (cnt_q == LAST_BIT) begin
            state_d = LATCH;
            out_d   = buf_d;
            rdy_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      LATCH:   if (fall) state_d = CAPTURE;
      CAPTURE: if (fall) state_d = DONE;
      DONE: begin
        snap    = enable;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // An out-of-range index never hits, so the cleared buffer returns 0.
    if (snap) begin
      state_d = SHIFT;
      cnt_d   = '0;
      sel_d   = active_select;
      in_d    = inputs;
      buf_d   = '0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      in_q    <= '0;
      buf_q   <= '0;
      out_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      in_q    <= in_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      rdy_q   <= rdy_d;
    end
  end
endmodule

// File: tb/tb_scan_chain_controller.sv
// Directed bench: 4-slot chain model behind a CLK_DIV=1 controller, plus a CLK_DIV=3 instance for timing.
module tb_scan_chain_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       en = 1'b0, en3 = 1'b0;
  logic [8:0] sel = '0, sel3 = '0;
  logic [7:0] din = '0, din3 = '0;
  logic [7:0] dout, dout3;
  logic       rdy, bsy, sck, sdo, ssel, slat, sdi;
  logic       rdy3, bsy3, sck3, sdo3, ssel3, slat3;
  logic       sdi3 = 1'b0;

  scan_chain_controller #(.NUM_DESIGNS(4), .CLK_DIV(1)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(en), .active_select(sel), .inputs(din),
    .outputs(dout), .ready(rdy), .busy(bsy), .scan_clk_out(sck), .scan_data_out(sdo),
    .scan_select(ssel), .scan_latch_en(slat), .scan_data_in(sdi)
  );

  scan_chain_controller #(.NUM_DESIGNS(4), .CLK_DIV(3)) dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(en3), .active_select(sel3), .inputs(din3),
    .outputs(dout3), .ready(rdy3), .busy(bsy3), .scan_clk_out(sck3), .scan_data_out(sdo3),
    .scan_select(ssel3), .scan_latch_en(slat3), .scan_data_in(sdi3)
  );

  // Chain model: slot 0 nearest the controller output, slot 3 feeds scan_data_in.
  logic [7:0] sr  [4];
  logic [7:0] lat [4];
  assign sdi = sr[3][7];

  always @(posedge sck or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) sr[k] <= '0;
    end else if (ssel) begin
      for (int k = 0; k < 4; k++) sr[k] <= lat[k] ^ 8'(k * 16);
    end else begin
      sr[0] <= {sr[0][6:0], sdo};
      for (int k = 1; k < 4; k++) sr[k] <= {sr[k][6:0], sr[k-1][7]};
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) lat[k] <= '0;
    end else if (slat) begin
      for (int k = 0; k < 4; k++) lat[k] <= sr[k];
    end
  end

  int ovl = 0;
  always @(negedge clk) if (!rst && ((slat && ssel) || (slat3 && ssel3))) ovl++;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_outputs"}, 32'(dout), 0);
    chk({pfx, "_ready"},   32'(rdy), 0);
    chk({pfx, "_busy"},    32'(bsy), 0);
    chk({pfx, "_sclk"},    32'(sck), 0);
    chk({pfx, "_sdata"},   32'(sdo), 0);
    chk({pfx, "_select"},  32'(ssel), 0);
    chk({pfx, "_latch"},   32'(slat), 0);
  endtask

  // what: 0 = scan_select high, 1 = controller idle
  task automatic wait_for(input int what, input int lim, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if ((what == 0 && ssel) || (what == 1 && !bsy)) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_frame(input logic [8:0] s, input logic [7:0] d,
                           output int bcnt, output int rcnt, output logic [7:0] rval);
    bcnt = 0; rcnt = 0; rval = '0;
    @(negedge clk); sel = s; din = d; en = 1'b1;
    @(negedge clk); en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!bsy) break;
      bcnt++;
      if (rdy) begin rcnt++; rval = dout; end
      @(negedge clk);
    end
  endtask

  typedef struct packed {
    logic [8:0]  s;
    logic [7:0]  d;
    logic [7:0]  eo;   // returned byte (previous frame's capture)
    logic [31:0] el;   // latched bytes, slots 3..0
  } vec_t;

  vec_t vt [7];

  initial begin
    int bc, rc, nr, t1, t2, b, lc, dh, r3, ri, cur;
    logic [7:0] rv, v1, v2;
    logic pv;
    bit ok;
    int rl [4];

    vt[0] = '{s: 9'd2, d: 8'hA5, eo: 8'h00, el: 32'h00A50000};
    vt[1] = '{s: 9'd1, d: 8'h5A, eo: 8'h10, el: 32'h00005A00};
    vt[2] = '{s: 9'd3, d: 8'hFF, eo: 8'h30, el: 32'hFF000000};
    vt[3] = '{s: 9'd7, d: 8'h77, eo: 8'h00, el: 32'h00000000};
    vt[4] = '{s: 9'd0, d: 8'h81, eo: 8'h00, el: 32'h00000081};
    vt[5] = '{s: 9'd0, d: 8'h00, eo: 8'h81, el: 32'h00000000};
    vt[6] = '{s: 9'd3, d: 8'hC3, eo: 8'h30, el: 32'hC3000000};

    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Reset asserted in the middle of SHIFT clears everything combinationally.
    @(negedge clk); sel = 9'd3; din = 8'hFF; en = 1'b1;
    @(negedge clk); en = 1'b0;
    repeat (8) @(negedge clk);
    chk("midreset_busy_before", 32'(bsy), 1);
    #2 rst = 1'b1;
    #1 chk_zero("midreset");
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_reset_idle_busy", 32'(bsy), 0);
    chk("post_reset_idle_sclk", 32'(sck), 0);

    for (int v = 0; v < 7; v++) begin
      run_frame(vt[v].s, vt[v].d, bc, rc, rv);
      chk($sformatf("vec%0d_busy_cycles", v), 32'(bc), 69);
      chk($sformatf("vec%0d_ready_pulses", v), 32'(rc), 1);
      chk($sformatf("vec%0d_outputs", v), 32'(rv), 32'(vt[v].eo));
      chk($sformatf("vec%0d_latched", v), {lat[3], lat[2], lat[1], lat[0]}, vt[v].el);
    end

    // Continuous mode: one-frame latency and 69-cycle frame spacing.
    @(negedge clk); sel = 9'd2; din = 8'hA5; en = 1'b1;
    nr = 0; t1 = 0; t2 = 0; v1 = '0; v2 = '0;
    for (int i = 0; i < 300 && nr < 2; i++) begin
      @(negedge clk);
      if (rdy) begin
        if (nr == 0) begin t1 = i; v1 = dout; end
        else begin t2 = i; v2 = dout; end
        nr++;
      end
    end
    en = 1'b0;
    chk("cont_ready_count", 32'(nr), 2);
    chk("cont_first_out", 32'(v1), 32'h20);
    chk("cont_second_out", 32'(v2), 32'h85);
    chk("cont_ready_spacing", 32'(t2 - t1), 69);
    wait_for(1, 200, ok);
    chk("cont_stop_idle", 32'(ok), 1);

    // Mid-frame input change and enable drop.
    @(negedge clk); sel = 9'd2; din = 8'hA5; en = 1'b1;
    repeat (10) @(negedge clk);
    din = 8'h3C;
    wait_for(0, 200, ok);
    chk("midchg_capture1_seen", 32'(ok), 1);
    chk("midchg_frame1_latch", {lat[3], lat[2], lat[1], lat[0]}, 32'h00A50000);
    repeat (20) @(negedge clk);
    chk("midchg_frame2_busy", 32'(bsy), 1);
    en = 1'b0;
    wait_for(0, 200, ok);
    chk("midchg_capture2_seen", 32'(ok), 1);
    chk("midchg_frame2_latch", {lat[3], lat[2], lat[1], lat[0]}, 32'h003C0000);
    wait_for(1, 200, ok);
    chk("midchg_idle", 32'(ok), 1);
    repeat (3) @(negedge clk);
    chk("midchg_stays_idle", 32'(bsy), 0);

    // CLK_DIV=3 timing.
    @(negedge clk); sel3 = 9'd2; din3 = 8'hFF; en3 = 1'b1;
    @(negedge clk); en3 = 1'b0;
    b = 0; lc = 0; dh = 0; r3 = 0; ri = 0; cur = 0; pv = 1'b0;
    for (int k = 0; k < 4; k++) rl[k] = 0;
    for (int i = 0; i < 400 && bsy3; i++) begin
      b++;
      if (slat3) lc++;
      if (sdo3) dh++;
      if (rdy3) r3++;
      if (ri < 4) begin
        if (sck3 == pv) cur++;
        else begin rl[ri] = cur; ri++; cur = 1; pv = sck3; end
      end
      @(negedge clk);
    end
    chk("div3_frame_cycles", 32'(b), 205);
    chk("div3_low0", 32'(rl[0]), 3);
    chk("div3_high0", 32'(rl[1]), 3);
    chk("div3_low1", 32'(rl[2]), 3);
    chk("div3_high1", 32'(rl[3]), 3);
    chk("div3_latch_width", 32'(lc), 6);
    chk("div3_data_high_cycles", 32'(dh), 48);
    chk("div3_ready_pulses", 32'(r3), 1);
    chk("div3_outputs", 32'(dout3), 0);

    chk("latch_select_overlap", 32'(ovl), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks so far", n_pass, n_chk);
    $fatal(1);
  end
endmodule

// File: doc/scan_chain_controller.md
Name: scan_chain_controller

Overview:
- Sequences the daisy-chained project scan chain inside the user project wrapper. Shifts 8 input bits into the selected project's slot and latches them into every project.
- Captures all project outputs, then shifts the chain out and returns the selected project's 8 outputs with a ready strobe.
- Sits between the top-level input/index pins and the chain. Replaces the hard-wired mode/index selection with a controllable, free-running or on-demand frame sequencer.

Parameters:
- NUM_DESIGNS, 250, number of 8-bit project slots in the chain (1..511).
- CLK_DIV, 2, wb_clk_i cycles per scan-clock half-period (>=1).

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  asynchronous active-high reset
- enable  in  1  high: run frames back-to-back; low: finish current frame, then idle
- active_select  in  9  project index to drive/observe
- inputs  in  8  input byte for selected project
- outputs  out  8  last returned output byte of selected project
- ready  out  1  one-cycle pulse when outputs is updated
- busy  out  1  high while a frame is in progress
- scan_clk_out  out  1  chain shift clock
- scan_data_out  out  1  serial data into chain
- scan_select  out  1  high: chain loads project outputs on next scan clock rise
- scan_latch_en  out  1  high: projects latch shifted inputs
- scan_data_in  in  1  serial data returning from chain end

Behaviour:
- Reset (async, immediate): state IDLE. All outputs 0: outputs, ready, busy, scan_clk_out, scan_data_out, scan_select, scan_latch_en. Counters and snapshots also 0.
- States:
  - IDLE -> SHIFT when enable=1 at a clock edge. On that edge, snapshot active_select and inputs; busy=1 from the next cycle.
  - SHIFT: N*8 scan clocks, N=NUM_DESIGNS.
  - LATCH: scan_latch_en=1 for 2*CLK_DIV cycles; scan_clk_out stays 0.
  - CAPTURE: scan_select=1 for one scan clock period (low half, then high half). Projects load outputs on the rising edge.
  - DONE: 1 cycle. Go to SHIFT (with a new snapshot) if enable=1, else IDLE with busy=0.
- Scan clock: each period is CLK_DIV cycles low, then CLK_DIV cycles high. It rests low outside SHIFT/CAPTURE.
- scan_data_out changes only on the first cycle of a low half.
- Shift bit count c=0..N*8-1, MSB first.
- Bit c ends in slot d = N-1-floor(c/8), bit 7-(c mod 8).
- scan_data_out = snapshot_inputs bit when d equals the snapshot index, else 0.
- scan_data_in is registered on the clock edge that drives scan_clk_out 0->1.
- The bit sampled at count c belongs to slot N-1-floor(c/8), same bit order. Bits for the snapshot index are assembled into a shift buffer.
- At the end of SHIFT, outputs <= buffer and ready pulses for 1 cycle, in the last SHIFT cycle + 1.
- Outputs returned in frame k are those captured in frame k-1: one-frame latency. The first frame after reset returns the chain's reset contents.
- If snapshot index >= NUM_DESIGNS: all shifted bits are 0, and outputs <= 8'h00 with ready still pulsed.
- Frame length in continuous mode: (N*8+2)*2*CLK_DIV + 1 cycles.
- enable dropping mid-frame never truncates a frame. active_select/inputs changes mid-frame are ignored until the next snapshot.
- scan_latch_en and scan_select are never both high.
- Counter widths: bit counter ceil(log2(N*8)) bits; divider ceil(log2(CLK_DIV)) bits, minimum 1.

Decomposition:
- Package scan_pkg:
  - state enum {IDLE, SHIFT, LATCH, CAPTURE, DONE};
  - BITS_PER_DESIGN=8; IDX_W=9.
- Sub-module scan_clk_gen: CLK_DIV half-period divider with run input.
  - Outputs scan_clk level, a fall_strobe (start of low half) and a rise_strobe (edge setting the clock high).
  - Controller FSM consumes the strobes.

Test Plan:
- Shared setup: NUM_DESIGNS=4, CLK_DIV=1. Bench chain model: 4 x 8-bit shift regs with latch and capture behaviour; project d outputs = latched_inputs ^ (8'h10*d).
- Reset: assert wb_rst_i mid-SHIFT -> all outputs 0 in the same cycle. Release with enable=0 -> stays IDLE, busy=0, scan_clk_out=0.
- Single frame: active_select=2, inputs=8'hA5, enable pulse 1 cycle -> slot 2 latches 8'hA5, other slots 8'h00, 69 cycles busy. ready pulses once.
- Latency: continuous enable, active_select=2, inputs=8'hA5 -> second ready gives outputs=8'hA5^8'h20=8'h85. Ready spacing 69 cycles.
- Out-of-range: active_select=9'd7 -> all slots latch 8'h00, outputs=8'h00, ready pulses.
- Mid-frame change: switch inputs to 8'h3C during SHIFT -> chain still latches 8'hA5; next frame latches 8'h3C. enable low mid-frame -> frame completes, then IDLE.
- CLK_DIV=3: scan_clk_out high/low 3 cycles each, frame 205 cycles. scan_latch_en width 6 cycles; never overlaps scan_select.
